// File: rtl/lsp_hist_update_if.sv
`timescale 1ns/1ps
// Request handshake plus scratch-memory bus of the LSP history update engine.
// The master side issues requests and serves reads; the slave side is the engine.
interface lsp_hist_update_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          start;
  logic          mode;
  logic [AW-1:0] newAddr;
  logic [AW-1:0] histAddr;
  logic [DW-1:0] memIn;
  logic [AW-1:0] memReadAddr;
  logic [AW-1:0] memWriteAddr;
  logic [DW-1:0] memOut;
  logic          memWriteEn;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, newAddr, histAddr, memIn,
    input  memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done
  );

  modport slave (
    input  start, mode, newAddr, histAddr, memIn,
    output memReadAddr, memWriteAddr, memOut, memWriteEn, busy, done
  );
endinterface

// File: rtl/lsp_hist_update.sv
`timescale 1ns/1ps
// MA-predictor history update: shifts (mode 0) or fills (mode 1) NP slots of M words
// in scratch memory with a pipelined copy engine that moves one vector every M+2 cycles.
module lsp_hist_update #(
  parameter int M      = 10,
  parameter int NP     = 4,
  parameter int STRIDE = 16,
  parameter int AW     = 12,
  parameter int DW     = 32
) (
  input logic              clk,
  input logic              reset,
  lsp_hist_update_if.slave bus
);

  localparam int EW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [AW-1:0] STRIDE_A  = AW'(STRIDE);
  localparam logic [AW-1:0] TOP_OFF   = AW'((NP - 1) * STRIDE);
  localparam logic [EW-1:0] LAST_ELEM = EW'(M - 1);
  localparam logic [CW-1:0] LAST_COPY = CW'(NP - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic [EW-1:0] elemIdx;
  logic [CW-1:0] copyIdx;
  logic          drainCnt;
  logic          latMode;
  logic [AW-1:0] latNew;
  logic [AW-1:0] srcBase;
  logic [AW-1:0] dstBase;

  logic          pipeValid;
  logic [AW-1:0] pipeAddr;

  logic [AW-1:0] readAddrQ;
  logic [AW-1:0] writeAddrQ;
  logic [DW-1:0] writeDataQ;
  logic          writeEnQ;
  logic          busyQ;
  logic          doneQ;

  logic [AW-1:0] firstDst;
  logic [AW-1:0] firstSrc;
  logic [AW-1:0] nextDst;
  logic [AW-1:0] nextSrc;
  logic [AW-1:0] nextRead;
  logic [EW-1:0] elemNext;
  logic [CW-1:0] copyNext;

  // Slots are visited top-down so a slot is always read before it is overwritten.
  assign firstDst = bus.histAddr + TOP_OFF;
  assign firstSrc = (bus.mode || NP == 1) ? bus.newAddr : firstDst - STRIDE_A;

  assign copyNext = copyIdx + 1'b1;
  assign nextDst  = dstBase - STRIDE_A;
  assign nextSrc  = (latMode || copyNext == LAST_COPY) ? latNew : nextDst - STRIDE_A;

  assign elemNext = elemIdx + 1'b1;
  assign nextRead = srcBase + AW'(elemNext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      elemIdx    <= '0;
      copyIdx    <= '0;
      drainCnt   <= 1'b0;
      latMode    <= 1'b0;
      latNew     <= '0;
      srcBase    <= '0;
      dstBase    <= '0;
      pipeValid  <= 1'b0;
      pipeAddr   <= '0;
      readAddrQ  <= '0;
      writeAddrQ <= '0;
      writeDataQ <= '0;
      writeEnQ   <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch below sees pre-edge values.
      // Write address travels with the read; data joins it when memIn becomes valid.
      pipeValid  <= (state == READ);
      pipeAddr   <= (state == READ) ? dstBase + AW'(elemIdx) : '0;
      writeEnQ   <= pipeValid;
      writeAddrQ <= pipeValid ? pipeAddr : '0;
      writeDataQ <= pipeValid ? bus.memIn : '0;

      case (state)
        IDLE: begin
          doneQ <= 1'b0;
          busyQ <= 1'b0;
          if (bus.start) begin
            latMode   <= bus.mode;
            latNew    <= bus.newAddr;
            srcBase   <= firstSrc;
            dstBase   <= firstDst;
            elemIdx   <= '0;
            copyIdx   <= '0;
            drainCnt  <= 1'b0;
            readAddrQ <= firstSrc;
            busyQ     <= 1'b1;
            state     <= READ;
          end
        end

        READ: begin
          if (elemIdx == LAST_ELEM) begin
            readAddrQ <= '0;
            drainCnt  <= 1'b0;
            state     <= DRAIN;
          end else begin
            elemIdx   <= elemNext;
            readAddrQ <= nextRead;
          end
        end

        DRAIN: begin
          if (!drainCnt) begin
            drainCnt <= 1'b1;
          end else if (copyIdx == LAST_COPY) begin
            drainCnt <= 1'b0;
            doneQ    <= 1'b1;
            state    <= DONE;
          end else begin
            drainCnt  <= 1'b0;
            copyIdx   <= copyNext;
            elemIdx   <= '0;
            srcBase   <= nextSrc;
            dstBase   <= nextDst;
            readAddrQ <= nextSrc;
            state     <= READ;
          end
        end

        DONE: begin
          doneQ   <= 1'b0;
          busyQ   <= 1'b0;
          elemIdx <= '0;
          copyIdx <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.memReadAddr  = readAddrQ;
  assign bus.memWriteAddr = writeAddrQ;
  assign bus.memOut       = writeDataQ;
  assign bus.memWriteEn   = writeEnQ;
  assign bus.busy         = busyQ;
  assign bus.done         = doneQ;

endmodule

// File: tb/tb_lsp_hist_update.sv
`timescale 1ns/1ps
// Bench for lsp_hist_update: table vectors, randomized runs against a copy-list model,
// a mid-operation abort and a single-slot instance with back-to-back requests.
module tb_lsp_hist_update;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int TM   = 10;
  localparam int TNP  = 4;
  localparam int TSTR = 16;
  localparam int MAXC = 120;
  localparam int MEMW = 1 << AW;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    bit            mode;
    logic [AW-1:0] newA;
    logic [AW-1:0] histA;
    logic [DW-1:0] srcPat;
    int            p1;
    int            p2;
    int            expWrites;
    int            expDone;
    logic [DW-1:0] eb0;
    logic [DW-1:0] eb1;
    logic [DW-1:0] eb2;
    logic [DW-1:0] eb3;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsp_hist_update_if #(.AW(AW), .DW(DW)) busA();
  lsp_hist_update_if #(.AW(AW), .DW(DW)) busB();

  lsp_hist_update #(.M(TM), .NP(TNP), .STRIDE(TSTR), .AW(AW), .DW(DW)) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );

  lsp_hist_update #(.M(3), .NP(1), .STRIDE(4), .AW(AW), .DW(DW)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  logic [DW-1:0] memA   [MEMW];
  logic [DW-1:0] initA  [MEMW];
  logic [DW-1:0] refMem [MEMW];
  logic [DW-1:0] memB   [MEMW];
  logic [DW-1:0] initB  [MEMW];
  bit            loadA = 1'b0;
  bit            loadB = 1'b0;
  int            writesInReset = 0;

  // Memories with one-cycle read latency; preload copies the init image in one edge.
  always @(posedge clk) begin
    busA.memIn <= memA[busA.memReadAddr];
    busB.memIn <= memB[busB.memReadAddr];
    if (loadA) foreach (memA[a]) memA[a] <= initA[a];
    else if (busA.memWriteEn) memA[busA.memWriteAddr] <= busA.memOut;
    if (loadB) foreach (memB[a]) memB[a] <= initB[a];
    else if (busB.memWriteEn) memB[busB.memWriteAddr] <= busB.memOut;
    if (!reset && (busA.memWriteEn || busB.memWriteEn)) writesInReset <= writesInReset + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  wr_t           expW[$];
  wr_t           obsW[$];
  logic [AW-1:0] expRead [MAXC+2];
  logic [AW-1:0] obsRead [MAXC+2];
  bit            obsBusy [MAXC+2];
  int            expDone, lastDone, doneCount, endCycle;

  // Reference: walk the copy list in order on a flat memory image.
  task automatic buildModel(input bit mode, input logic [AW-1:0] newA, input logic [AW-1:0] histA);
    logic [AW-1:0] src, dst, sa, da;
    int rc;
    wr_t w;
    expW.delete();
    foreach (expRead[c]) expRead[c] = '0;
    foreach (refMem[a]) refMem[a] = initA[a];
    for (int j = 0; j < TNP; j++) begin
      dst = histA + AW'((TNP - 1 - j) * TSTR);
      if (mode) src = newA;
      else if (j < TNP - 1) src = histA + AW'((TNP - 2 - j) * TSTR);
      else src = newA;
      for (int i = 0; i < TM; i++) begin
        sa = src + AW'(i);
        da = dst + AW'(i);
        rc = 1 + j * (TM + 2) + i;
        expRead[rc] = sa;
        refMem[da] = refMem[sa];
        w.cyc = rc + 2;
        w.addr = da;
        w.data = refMem[da];
        expW.push_back(w);
      end
    end
    expDone = TNP * (TM + 2) + 1;
  endtask

  task automatic doLoadA();
    loadA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    loadA = 1'b0;
  endtask

  task automatic runOp(input bit mode, input logic [AW-1:0] newA, input logic [AW-1:0] histA,
                       input int p1, input int p2);
    int nb;
    wr_t w;
    buildModel(mode, newA, histA);
    obsW.delete();
    foreach (obsRead[c]) begin obsRead[c] = '0; obsBusy[c] = 1'b0; end
    lastDone = 0; doneCount = 0; endCycle = 0;
    busA.start = 1'b1; busA.mode = mode; busA.newAddr = newA; busA.histAddr = histA;
    @(posedge clk);
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      if (c == p1 || c == p2) begin
        busA.start = 1'b1; busA.mode = ~mode;
        busA.newAddr = newA ^ 12'h5A5; busA.histAddr = histA + 12'h200;
      end else begin
        busA.start = 1'b0;
      end
      obsRead[c] = busA.memReadAddr;
      obsBusy[c] = busA.busy;
      if (busA.memWriteEn) begin
        w.cyc = c; w.addr = busA.memWriteAddr; w.data = busA.memOut;
        obsW.push_back(w);
      end
      if (busA.done) begin doneCount++; lastDone = c; end
      endCycle = c;
      if (lastDone != 0 && c == lastDone + 1) break;
    end
    busA.start = 1'b0;
    check("done_count", doneCount, 1);
    check("done_cycle", lastDone, expDone);
    check("write_count", obsW.size(), expW.size());
    nb = 0;
    for (int k = 0; k < obsW.size() && k < expW.size(); k++)
      if (obsW[k].cyc != expW[k].cyc || obsW[k].addr !== expW[k].addr || obsW[k].data !== expW[k].data) nb++;
    check("write_trace_mismatches", nb, 0);
    nb = 0;
    for (int c = 1; c <= expDone + 1 && c <= endCycle; c++)
      if (obsRead[c] !== expRead[c]) nb++;
    check("read_trace_mismatches", nb, 0);
    nb = 0;
    for (int c = 1; c <= expDone + 1 && c <= endCycle; c++)
      if (obsBusy[c] != (c <= expDone)) nb++;
    check("busy_window_mismatches", nb, 0);
    nb = 0;
    foreach (memA[a]) if (memA[a] !== refMem[a]) nb++;
    check("mem_final_mismatches", nb, 0);
  endtask

  function automatic vec_t mkVec(bit mode, logic [AW-1:0] newA, logic [AW-1:0] histA,
                                 logic [DW-1:0] srcPat, int p1, int p2,
                                 logic [DW-1:0] e0, logic [DW-1:0] e1,
                                 logic [DW-1:0] e2, logic [DW-1:0] e3);
    vec_t v;
    v.mode = mode; v.newA = newA; v.histA = histA; v.srcPat = srcPat;
    v.p1 = p1; v.p2 = p2; v.expWrites = 40; v.expDone = 49;
    v.eb0 = e0; v.eb1 = e1; v.eb2 = e2; v.eb3 = e3;
    return v;
  endfunction

  function automatic logic [DW-1:0] ebOf(vec_t v, int k);
    case (k)
      0: return v.eb0;
      1: return v.eb1;
      2: return v.eb2;
      default: return v.eb3;
    endcase
  endfunction

  task automatic preloadVec(vec_t v);
    foreach (initA[a]) initA[a] = $urandom;
    for (int k = 0; k < TNP; k++)
      for (int i = 0; i < TM; i++)
        initA[v.histA + AW'(k * TSTR + i)] = DW'(100 * k + i);
    for (int i = 0; i < TM; i++) initA[v.newA + AW'(i)] = v.srcPat + DW'(i);
    doLoadA();
  endtask

  vec_t vecs[5];
  wr_t  bExp[6];
  wr_t  bObs[$];
  int   bDone[$];
  bit   bBusy [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [AW-1:0] newA, histA;
    bit mode;
    wr_t w;

    vecs[0] = mkVec(1'b0, 12'h100, 12'h040, 32'd900, 0, 0, 900, 0, 100, 200);
    vecs[1] = mkVec(1'b1, 12'h100, 12'h040, 32'hA0, 0, 0, 32'hA0, 32'hA0, 32'hA0, 32'hA0);
    vecs[2] = mkVec(1'b0, 12'h100, 12'h040, 32'd900, 5, 49, 900, 0, 100, 200);
    vecs[3] = mkVec(1'b0, 12'h200, 12'hFE0, 32'd900, 0, 0, 900, 0, 100, 200);
    vecs[4] = mkVec(1'b1, 12'h0FF, 12'h5A3, 32'h1234, 0, 0, 32'h1234, 32'h1234, 32'h1234, 32'h1234);

    busA.start = 1'b0; busA.mode = 1'b0; busA.newAddr = '0; busA.histAddr = '0;
    busB.start = 1'b0; busB.mode = 1'b0; busB.newAddr = '0; busB.histAddr = '0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busA.busy, busA.done, busA.memWriteEn, busA.memReadAddr,
                              busA.memWriteAddr, busA.memOut}, 64'd0);
    check("reset_outputs_b", {busB.busy, busB.done, busB.memWriteEn, busB.memReadAddr,
                              busB.memWriteAddr, busB.memOut}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[n]) begin
      preloadVec(vecs[n]);
      runOp(vecs[n].mode, vecs[n].newA, vecs[n].histA, vecs[n].p1, vecs[n].p2);
      check("tbl_done_cycle", lastDone, vecs[n].expDone);
      check("tbl_write_count", obsW.size(), vecs[n].expWrites);
      nb = 0;
      for (int k = 0; k < TNP; k++)
        for (int i = 0; i < TM; i++)
          if (memA[vecs[n].histA + AW'(k * TSTR + i)] !== ebOf(vecs[n], k) + DW'(i)) nb++;
      check("tbl_slot_mismatches", nb, 0);
      if (vecs[n].mode == 1'b0) begin
        nb = 0;
        foreach (obsW[k])
          for (int i = 0; i < TM; i++)
            if (obsW[k].addr == vecs[n].histA + AW'(48 + i) &&
                (obsW[k].cyc < 3 || obsRead[obsW[k].cyc - 2] !== vecs[n].histA + AW'(32 + i))) nb++;
        check("probe_read_to_write_lag", nb, 0);
      end
    end

    for (int r = 0; r < 6; r++) begin
      mode  = 1'($urandom_range(0, 1));
      histA = AW'($urandom_range(12'h400, 12'hF00));
      newA  = AW'($urandom_range(0, 12'h3F0));
      foreach (initA[a]) initA[a] = $urandom;
      doLoadA();
      runOp(mode, newA, histA, 0, 0);
    end
    // Back-to-back: the next start lands in the cycle right after done.
    foreach (initA[a]) initA[a] = memA[a];
    runOp(1'b1, 12'h123, 12'h800, 0, 0);

    preloadVec(vecs[0]);
    buildModel(1'b0, 12'h100, 12'h040);
    foreach (refMem[a]) refMem[a] = initA[a];
    foreach (expW[k]) if (expW[k].cyc < 20) refMem[expW[k].addr] = expW[k].data;
    busA.start = 1'b1; busA.mode = 1'b0; busA.newAddr = 12'h100; busA.histAddr = 12'h040;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      busA.start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_outputs", {busA.busy, busA.done, busA.memWriteEn, busA.memReadAddr,
                            busA.memWriteAddr, busA.memOut}, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_outputs_held", {busA.busy, busA.memWriteEn, busA.memReadAddr}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    nb = 0;
    foreach (memA[a]) if (memA[a] !== refMem[a]) nb++;
    check("abort_mem_mismatches", nb, 0);
    check("abort_slot3_w9", memA[12'h079], 32'd209);
    check("abort_slot2_w4", memA[12'h064], 32'd104);
    check("abort_slot2_w5", memA[12'h065], 32'd205);
    check("abort_slot1_w0", memA[12'h050], 32'd100);
    preloadVec(vecs[0]);
    runOp(1'b0, 12'h100, 12'h040, 0, 0);

    foreach (initB[a]) initB[a] = $urandom;
    for (int i = 0; i < 3; i++) begin
      initB[12'h010 + AW'(i)] = 32'h70 + DW'(i);
      initB[12'h020 + AW'(i)] = 32'h55 + DW'(i);
      initB[12'h030 + AW'(i)] = 32'h99 + DW'(i);
    end
    for (int i = 0; i < 3; i++) begin
      bExp[i].cyc = 3 + i;      bExp[i].addr = 12'h010 + AW'(i);     bExp[i].data = 32'h55 + DW'(i);
      bExp[i + 3].cyc = 10 + i; bExp[i + 3].addr = 12'h010 + AW'(i); bExp[i + 3].data = 32'h99 + DW'(i);
    end
    loadB = 1'b1;
    @(posedge clk);
    @(negedge clk);
    loadB = 1'b0;
    busB.start = 1'b1; busB.mode = 1'b0; busB.newAddr = 12'h020; busB.histAddr = 12'h010;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 7) begin
        busB.start = 1'b1; busB.mode = 1'b1; busB.newAddr = 12'h030;
      end else begin
        busB.start = 1'b0;
      end
      bBusy[c] = busB.busy;
      if (busB.memWriteEn) begin
        w.cyc = c; w.addr = busB.memWriteAddr; w.data = busB.memOut;
        bObs.push_back(w);
      end
      if (busB.done) bDone.push_back(c);
    end
    check("np1_write_count", bObs.size(), 6);
    nb = 0;
    for (int k = 0; k < bObs.size() && k < 6; k++)
      if (bObs[k].cyc != bExp[k].cyc || bObs[k].addr !== bExp[k].addr || bObs[k].data !== bExp[k].data) nb++;
    check("np1_write_trace_mismatches", nb, 0);
    check("np1_done_count", bDone.size(), 2);
    check("np1_done_first", (bDone.size() > 0) ? bDone[0] : -1, 6);
    check("np1_done_second", (bDone.size() > 1) ? bDone[1] : -1, 13);
    check("np1_busy_cycle7", bBusy[7], 0);
    check("np1_busy_cycle8", bBusy[8], 1);
    check("np1_slot0_w2", memB[12'h012], 32'h9B);

    check("writes_during_reset", writesInReset, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
